// File: rtl/isolde_vli_fetch_buffer.sv
// ----------------------------------------------------------------------------
// isolde_vli_fetch_buffer
// Aligns a stream of 32-bit fetch words into variable-length instruction
// batches (1..5 words) for the ISOLDE custom instruction decoder. Words are
// queued in a circular buffer. The header word at the read pointer sets the
// instruction length. Once all of its words are present, the instruction is
// presented as a 5-word batch, and it is popped when the decoder acknowledges.
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   flush_i        synchronous discard of all buffered words (beats push/pop)
//   in_valid_i     fetch word valid
//   in_word_i      fetch word
//   in_ready_o     buffer accepts a word this cycle (space, or a pop this cycle)
//   batch_o        batch_o[k] = k-th word of current instruction, 0 beyond length
//   batch_len_o    current instruction length in words (1..5)
//   batch_valid_o  all batch_len_o words are buffered
//   batch_ack_i    decoder consumes the current batch
//   len_err_o      current header carries an illegal length code
//   count_o        number of buffered words
// ----------------------------------------------------------------------------

// Assertion checker: the occupancy bound, the handshake and the length range.
module isolde_vli_fetch_buffer_chk #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             push_i,
  input logic             in_ready_i,
  input logic [CNT_W-1:0] count_i,
  input logic [2:0]       batch_len_i
);

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_i <= CNT_W'(DEPTH));

  a_push_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push_i |-> in_ready_i);

  a_len_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (batch_len_i >= 3'd1) && (batch_len_i <= 3'd5));

endmodule

module isolde_vli_fetch_buffer #(
  parameter int unsigned DEPTH       = 8,
  parameter logic [6:0]  VLEN_OPCODE = 7'h5B
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  input  logic [31:0]                in_word_i,
  output logic                       in_ready_o,
  output logic [4:0][31:0]           batch_o,
  output logic [2:0]                 batch_len_o,
  output logic                       batch_valid_o,
  input  logic                       batch_ack_i,
  output logic                       len_err_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [2:0]       len_s;
  logic             len_err_s;
  logic             batch_valid_s;
  logic             pop_req_s;
  logic             pop_s;
  logic             push_s;
  logic             in_ready_s;
  logic [4:0][31:0] batch_s;
  logic [2:0]       len_code_s;

  // Length decode of the header word at the read pointer.
  always_comb begin
    len_s      = 3'd1;
    len_err_s  = 1'b0;
    len_code_s = mem_q[rd_ptr_q][14:12];
    if ((count_q != {CNT_W{1'b0}}) && (mem_q[rd_ptr_q][6:0] == VLEN_OPCODE)) begin
      if (len_code_s <= 3'd4) begin
        len_s = len_code_s + 3'd1;
      end else begin
        // An illegal code is treated as a single word so the stream keeps moving.
        len_err_s = 1'b1;
      end
    end else begin
      len_s = 3'd1;
    end
  end

  // Handshake decode. in_ready accepts a pop in the same cycle, which frees space.
  always_comb begin
    batch_valid_s = (count_q >= CNT_W'(len_s));
    pop_req_s     = batch_valid_s && batch_ack_i;
    in_ready_s    = (count_q < DEPTH_C) || pop_req_s;
    pop_s         = pop_req_s && !flush_i;
    push_s        = in_valid_i && in_ready_s && !flush_i;
  end

  // Batch view. Slots at or beyond the instruction length read as zero.
  always_comb begin
    batch_s = '0;
    for (int k = 0; k < 5; k++) begin
      if ((count_q != {CNT_W{1'b0}}) && (3'(k) < len_s)) begin
        batch_s[k] = mem_q[rd_ptr_q + PTR_W'(k)];
      end else begin
        batch_s[k] = 32'h0000_0000;
      end
    end
  end

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(len_s);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_s}
                - (pop_s ? CNT_W'(len_s) : {CNT_W{1'b0}});
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage. Contents are only visible through occupied slots.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_word_i;
    end
  end

  assign in_ready_o    = in_ready_s;
  assign batch_o       = batch_s;
  assign batch_len_o   = len_s;
  assign batch_valid_o = batch_valid_s;
  assign len_err_o     = len_err_s;
  assign count_o       = count_q;

  isolde_vli_fetch_buffer_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_s),
    .in_ready_i  (in_ready_s),
    .count_i     (count_q),
    .batch_len_i (len_s)
  );

endmodule

// File: tb/tb_isolde_vli_fetch_buffer.sv
// Directed table-driven bench for isolde_vli_fetch_buffer (DEPTH=8).
// Each row gives the inputs for one cycle and the outputs expected in that
// cycle, before the clock edge that registers them.
module tb_isolde_vli_fetch_buffer;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             in_valid_i;
  logic [31:0]      in_word_i;
  logic             in_ready_o;
  logic [4:0][31:0] batch_o;
  logic [2:0]       batch_len_o;
  logic             batch_valid_o;
  logic             batch_ack_i;
  logic             len_err_o;
  logic [3:0]       count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  isolde_vli_fetch_buffer #(.DEPTH(8), .VLEN_OPCODE(7'h5B)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_word_i     (in_word_i),
    .in_ready_o    (in_ready_o),
    .batch_o       (batch_o),
    .batch_len_o   (batch_len_o),
    .batch_valid_o (batch_valid_o),
    .batch_ack_i   (batch_ack_i),
    .len_err_o     (len_err_o),
    .count_o       (count_o)
  );

  typedef struct {
    logic             fl;
    logic             iv;
    logic [31:0]      w;
    logic             ack;
    logic             rdy;
    logic             vld;
    logic [2:0]       len;
    logic             err;
    logic [3:0]       cnt;
    logic             cb;   // compare batch_o in this row
    logic [4:0][31:0] b;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic iv, input logic [31:0] w,
                              input logic ack, input logic rdy, input logic vld,
                              input logic [2:0] len, input logic err, input logic [3:0] cnt,
                              input logic cb, input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3, input logic [31:0] b4);
    vec_t v;
    v.fl = fl; v.iv = iv; v.w = w; v.ack = ack;
    v.rdy = rdy; v.vld = vld; v.len = len; v.err = err; v.cnt = cnt; v.cb = cb;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".ready"}, 32'(in_ready_o), 32'd1);
    chk({tag, ".valid"}, 32'(batch_valid_o), 32'd0);
    chk({tag, ".len"}, 32'(batch_len_o), 32'd1);
    chk({tag, ".err"}, 32'(len_err_o), 32'd0);
    chk({tag, ".count"}, 32'(count_o), 32'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("%s.b%0d", tag, k), batch_o[k], 32'h0);
  endtask

  function automatic logic [31:0] wf(input int i);  // full-test words, 1-word instrs
    return 32'hA000_0033 | (32'(i) << 8);
  endfunction

  function automatic logic [31:0] pw(input int i);  // wrap-test words, 1-word instrs
    return 32'h0000_0033 | (32'(i) << 16);
  endfunction

  function automatic logic [31:0] dw(input int i);  // body words of long instrs
    return 32'hD000_0000 | 32'(i);
  endfunction

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; in_word_i = 32'h0; batch_ack_i = 1'b0;

    // single-word instruction, popped the cycle after it is pushed
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h33,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd1,0,4'd1, 1, 32'h33,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    // 4-word instruction; the ack while partial is ignored
    vecs.push_back(mk(0,1,32'h305B,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h11111111,0, 1,0,3'd4,0,4'd1, 0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h22222222,1, 1,0,3'd4,0,4'd2, 0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h33333333,0, 1,0,3'd4,0,4'd3, 0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,1,3'd4,0,4'd4, 1, 32'h305B,32'h11111111,32'h22222222,32'h33333333,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd4,0,4'd4, 1, 32'h305B,32'h11111111,32'h22222222,32'h33333333,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    // illegal length codes 7 and 5 pop as one word each
    vecs.push_back(mk(0,1,32'h705B,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h505B,0, 1,1,3'd1,1,4'd1, 1, 32'h705B,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd1,1,4'd2, 1, 32'h705B,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd1,1,4'd1, 1, 32'h505B,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    // fill to 8, refused push, push+ack at full, drain
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,1,wf(i),0, 1,(i > 0),3'd1,0,4'(i), 1, (i > 0) ? wf(0) : 32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,32'hDEAD0033,0, 0,1,3'd1,0,4'd8, 1, wf(0),0,0,0,0));
    vecs.push_back(mk(0,1,wf(8),1, 1,1,3'd1,0,4'd8, 1, wf(0),0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 0,1,3'd1,0,4'd8, 1, wf(1),0,0,0,0));
    for (int j = 0; j < 8; j++)
      vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd1,0,4'(8 - j), 1, wf(j + 1),0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    // 13 back-to-back 1-word instrs leave rd_ptr at 5; 5-word instr wraps 7->0
    vecs.push_back(mk(0,1,pw(0),0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    for (int k = 1; k < 13; k++)
      vecs.push_back(mk(0,1,pw(k),1, 1,1,3'd1,0,4'd1, 1, pw(k - 1),0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd1,0,4'd1, 1, pw(12),0,0,0,0));
    vecs.push_back(mk(0,1,32'h405B,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    for (int k = 1; k < 5; k++)
      vecs.push_back(mk(0,1,dw(k),0, 1,0,3'd5,0,4'(k), 0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd5,0,4'd5, 1, 32'h405B,dw(1),dw(2),dw(3),dw(4)));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    // flush with 3 of 5 words buffered; the word offered with flush is dropped
    vecs.push_back(mk(0,1,32'h405B,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,dw(1),0, 1,0,3'd5,0,4'd1, 0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,dw(2),0, 1,0,3'd5,0,4'd2, 0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,32'h00000099,1, 1,0,3'd5,0,4'd3, 0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,32'h33,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,1, 1,1,3'd1,0,4'd1, 1, 32'h33,0,0,0,0));
    vecs.push_back(mk(0,0,32'h0,0, 1,0,3'd1,0,4'd0, 1, 0,0,0,0,0));

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1 check_idle("in_reset");
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      flush_i = vecs[i].fl; in_valid_i = vecs[i].iv; in_word_i = vecs[i].w; batch_ack_i = vecs[i].ack;
      #1;
      chk($sformatf("v%0d.ready", i), 32'(in_ready_o), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.valid", i), 32'(batch_valid_o), 32'(vecs[i].vld));
      chk($sformatf("v%0d.len", i), 32'(batch_len_o), 32'(vecs[i].len));
      chk($sformatf("v%0d.err", i), 32'(len_err_o), 32'(vecs[i].err));
      chk($sformatf("v%0d.count", i), 32'(count_o), 32'(vecs[i].cnt));
      if (vecs[i].cb) begin
        for (int k = 0; k < 5; k++)
          chk($sformatf("v%0d.b%0d", i, k), batch_o[k], vecs[i].b[k]);
      end
    end

    // async reset in the middle of a 5-word instruction
    @(negedge clk_i);
    flush_i = 1'b0; batch_ack_i = 1'b0; in_valid_i = 1'b1; in_word_i = 32'h405B;
    @(negedge clk_i); in_word_i = dw(1);
    @(negedge clk_i); in_word_i = dw(2);
    #1 chk("rst.pre_count", 32'(count_o), 32'd2);
    chk("rst.pre_len", 32'(batch_len_o), 32'd5);
    #1 rst_ni = 1'b0;
    #1 check_idle("rst.async");
    @(posedge clk_i);
    #1 check_idle("rst.held");
    @(negedge clk_i);
    rst_ni = 1'b1; in_valid_i = 1'b0;
    #1 check_idle("rst.release");
    @(negedge clk_i); in_valid_i = 1'b1; in_word_i = 32'h33;
    @(negedge clk_i); in_valid_i = 1'b0; batch_ack_i = 1'b1;
    #1 chk("rst.after_valid", 32'(batch_valid_o), 32'd1);
    chk("rst.after_count", 32'(count_o), 32'd1);
    chk("rst.after_b0", batch_o[0], 32'h33);
    chk("rst.after_b1", batch_o[1], 32'h0);
    @(negedge clk_i); batch_ack_i = 1'b0;
    #1 check_idle("rst.drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
